hdmi_period_scheduler: RTL and testbench

- Sequences the TMDS encoders for one HDMI/DVI output and replaces the bare timing generator.
- Runs the raster counters and decides, per pixclk, the transmission period: control, video preamble, video guard band or active video.
- Drives VDE and the per-channel control bits for the three TMDS_encoder instances.
- Issues pixel fetch requests FETCH_LEAD cycles ahead, so the Tetris renderer/board RAM can return colour data aligned with VDE.

---
 rtl/hdmi_pkg.sv | 28 ++
 rtl/hdmi_period_scheduler_if.sv | 29 ++
 rtl/hdmi_period_scheduler_raster_counter.sv | 35 +++
 rtl/hdmi_period_scheduler.sv | 154 +++++++++++++++
 tb/tb_hdmi_period_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - shared period encoding, control-period patterns and default raster timing
package hdmi_pkg;

    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        PERIOD_CTRL     = 2'd0,
        PERIOD_PREAMBLE = 2'd1,
        PERIOD_GUARD    = 2'd2,
        PERIOD_VIDEO    = 2'd3
    } period_t;

    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;

    // CTL3..CTL0 = 0001 announces a video data period on the green/red channels
    localparam logic [1:0] CTL_PREAMBLE = 2'b01;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

endpackage

// File: rtl/hdmi_period_scheduler_if.sv
// rtl/hdmi_period_scheduler_if.sv - encoder sequencing, sync and pixel fetch bundle
interface hdmi_period_scheduler_if;
    import hdmi_pkg::*;

    logic               VDE;
    logic [1:0]         period;
    logic [1:0]         CD_blue;
    logic [1:0]         CD_green;
    logic [1:0]         CD_red;
    logic               hsync;
    logic               vsync;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               frame_start;
    logic               fetch_valid;
    logic [COORD_W-1:0] fetch_x;
    logic [COORD_W-1:0] fetch_y;

    modport master (
        output VDE, period, CD_blue, CD_green, CD_red, hsync, vsync,
        output x, y, frame_start, fetch_valid, fetch_x, fetch_y
    );

    modport slave (
        input VDE, period, CD_blue, CD_green, CD_red, hsync, vsync,
        input x, y, frame_start, fetch_valid, fetch_x, fetch_y
    );

endinterface

// File: rtl/hdmi_period_scheduler_raster_counter.sv
// rtl/hdmi_period_scheduler_raster_counter.sv - x/y raster counter starting OFFSET pixels ahead of origin
module raster_counter
    import hdmi_pkg::*;
#(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int OFFSET  = 0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y
);

    localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(V_TOTAL - 1);
    // Reset position is the raster point OFFSET pixels after (0,0), so a lookahead
    // instance stays a fixed distance ahead of the display instance forever.
    localparam logic [COORD_W-1:0] X_START = COORD_W'(OFFSET % H_TOTAL);
    localparam logic [COORD_W-1:0] Y_START = COORD_W'((OFFSET / H_TOTAL) % V_TOTAL);

    // Advance one pixel per clock, wrapping lines and frames
    always_ff @(posedge clk) begin
        if (rst) begin
            x <= X_START;
            y <= Y_START;
        end else if (x == X_LAST) begin
            x <= '0;
            y <= (y == Y_LAST) ? '0 : y + 1'b1;
        end else begin
            x <= x + 1'b1;
        end
    end

endmodule

// File: rtl/hdmi_period_scheduler.sv
// rtl/hdmi_period_scheduler.sv - raster timing, TMDS period selection and pixel fetch requests
module hdmi_period_scheduler
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit SYNC_POL   = 1'b0,
    parameter bit DVI_MODE   = 1'b0,
    parameter int FETCH_LEAD = 2
) (
    input  logic                      pixclk,
    input  logic                      rst,
    hdmi_period_scheduler_if.master   vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("hdmi_period_scheduler: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (FETCH_LEAD < 1 || FETCH_LEAD > 8) begin : g_bad_lead
        $error("hdmi_period_scheduler: FETCH_LEAD must be in 1..8");
    end

    // Comparisons use one extra bit so a boundary equal to 1024 does not alias to 0
    localparam logic [COORD_W:0] H_ACT_C     = (COORD_W+1)'(H_ACTIVE);
    localparam logic [COORD_W:0] HS_BEG_C    = (COORD_W+1)'(H_ACTIVE + H_FP);
    localparam logic [COORD_W:0] HS_END_C    = (COORD_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W:0] PRE_BEG_C   = (COORD_W+1)'(H_TOTAL - PREAMBLE_LEN - GUARD_LEN);
    localparam logic [COORD_W:0] PRE_END_C   = (COORD_W+1)'(H_TOTAL - GUARD_LEN - 1);
    localparam logic [COORD_W:0] GRD_BEG_C   = (COORD_W+1)'(H_TOTAL - GUARD_LEN);
    localparam logic [COORD_W:0] V_ACT_C     = (COORD_W+1)'(V_ACTIVE);
    localparam logic [COORD_W:0] V_NL_LAST_C = (COORD_W+1)'(V_ACTIVE - 1);
    localparam logic [COORD_W:0] V_LAST_C    = (COORD_W+1)'(V_TOTAL - 1);
    localparam logic [COORD_W:0] VS_BEG_C    = (COORD_W+1)'(V_ACTIVE + V_FP);
    localparam logic [COORD_W:0] VS_END_C    = (COORD_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [COORD_W-1:0] disp_x;
    logic [COORD_W-1:0] disp_y;
    logic [COORD_W-1:0] look_x;
    logic [COORD_W-1:0] look_y;

    raster_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .OFFSET  (0)
    ) u_disp_counter (
        .clk (pixclk),
        .rst (rst),
        .x   (disp_x),
        .y   (disp_y)
    );

    raster_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .OFFSET  (FETCH_LEAD)
    ) u_fetch_counter (
        .clk (pixclk),
        .rst (rst),
        .x   (look_x),
        .y   (look_y)
    );

    logic [COORD_W:0] dx;
    logic [COORD_W:0] dy;
    logic [COORD_W:0] fx;
    logic [COORD_W:0] fy;

    assign dx = {1'b0, disp_x};
    assign dy = {1'b0, disp_y};
    assign fx = {1'b0, look_x};
    assign fy = {1'b0, look_y};

    logic video;
    logic next_line_active;
    logic in_preamble;
    logic in_guard;
    logic hs_lvl;
    logic vs_lvl;
    logic fetch_hit;

    assign video            = (dx < H_ACT_C) && (dy < V_ACT_C);
    // The line after this one carries video: any active line but the last, or the final blanking line
    assign next_line_active = (dy < V_NL_LAST_C) || (dy == V_LAST_C);
    assign in_preamble      = !DVI_MODE && next_line_active && (dx >= PRE_BEG_C) && (dx <= PRE_END_C);
    assign in_guard         = !DVI_MODE && next_line_active && (dx >= GRD_BEG_C);
    assign hs_lvl           = ((dx >= HS_BEG_C) && (dx < HS_END_C)) ? SYNC_POL : ~SYNC_POL;
    assign vs_lvl           = ((dy >= VS_BEG_C) && (dy < VS_END_C)) ? SYNC_POL : ~SYNC_POL;
    assign fetch_hit        = (fx < H_ACT_C) && (fy < V_ACT_C);

    period_t    period_n;
    logic [1:0] cd_blue_n;
    logic [1:0] cd_green_n;

    // Choose the transmission period and encoder control bits for the current pixel
    always_comb begin
        period_n   = PERIOD_CTRL;
        cd_blue_n  = {vs_lvl, hs_lvl};
        cd_green_n = 2'b00;
        if (video) begin
            period_n  = PERIOD_VIDEO;
            cd_blue_n = 2'b00;
        end else if (in_preamble) begin
            period_n   = PERIOD_PREAMBLE;
            cd_green_n = CTL_PREAMBLE;
        end else if (in_guard) begin
            period_n = PERIOD_GUARD;
        end
    end

    // Register every output; fetch coordinates hold between valid requests
    always_ff @(posedge pixclk) begin
        if (rst) begin
            vid.VDE         <= 1'b0;
            vid.period      <= PERIOD_CTRL;
            vid.CD_blue     <= 2'b00;
            vid.CD_green    <= 2'b00;
            vid.CD_red      <= 2'b00;
            vid.hsync       <= ~SYNC_POL;
            vid.vsync       <= ~SYNC_POL;
            vid.x           <= '0;
            vid.y           <= '0;
            vid.frame_start <= 1'b0;
            vid.fetch_valid <= 1'b0;
            vid.fetch_x     <= '0;
            vid.fetch_y     <= '0;
        end else begin
            vid.VDE         <= video;
            vid.period      <= period_n;
            vid.CD_blue     <= cd_blue_n;
            vid.CD_green    <= cd_green_n;
            vid.CD_red      <= 2'b00;
            vid.hsync       <= hs_lvl;
            vid.vsync       <= vs_lvl;
            vid.x           <= disp_x;
            vid.y           <= disp_y;
            vid.frame_start <= (disp_x == '0) && (disp_y == '0);
            vid.fetch_valid <= fetch_hit;
            if (fetch_hit) begin
                vid.fetch_x <= look_x;
                vid.fetch_y <= look_y;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// tb/tb_hdmi_period_scheduler.sv - randomized self-checking bench for hdmi_period_scheduler
module tb_hdmi_period_scheduler;

    typedef struct {
        int ha, hfp, hs, hbp;
        int va, vfp, vs, vbp;
        int pol, dvi, lead;
    } cfg_t;

    typedef struct packed {
        logic       vde;
        logic [1:0] period;
        logic [1:0] cdb;
        logic [1:0] cdg;
        logic [1:0] cdr;
        logic       hs;
        logic       vs;
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
        logic       fv;
        logic [9:0] fx;
        logic [9:0] fy;
    } out_t;

    logic pixclk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;
    logic [2:0] rst_s = 3'b111;

    int n_checks = 0;
    int n_errors = 0;

    always #5 pixclk = ~pixclk;

    hdmi_period_scheduler_if ifa ();
    hdmi_period_scheduler_if ifb ();
    hdmi_period_scheduler_if ifc ();

    hdmi_period_scheduler #(
        .FETCH_LEAD (2)
    ) dut_a (
        .pixclk (pixclk),
        .rst    (rst_a),
        .vid    (ifa)
    );

    hdmi_period_scheduler #(
        .H_ACTIVE (16), .H_FP (4), .H_SYNC (6), .H_BP (6),
        .V_ACTIVE (8),  .V_FP (2), .V_SYNC (2), .V_BP (3),
        .SYNC_POL (1'b1), .DVI_MODE (1'b0), .FETCH_LEAD (8)
    ) dut_b (
        .pixclk (pixclk),
        .rst    (rst_b),
        .vid    (ifb)
    );

    hdmi_period_scheduler #(
        .H_ACTIVE (20), .H_FP (2), .H_SYNC (3), .H_BP (5),
        .V_ACTIVE (6),  .V_FP (1), .V_SYNC (2), .V_BP (2),
        .SYNC_POL (1'b0), .DVI_MODE (1'b1), .FETCH_LEAD (1)
    ) dut_c (
        .pixclk (pixclk),
        .rst    (rst_c),
        .vid    (ifc)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int frame_len(input cfg_t c);
        return (c.ha + c.hfp + c.hs + c.hbp) * (c.va + c.vfp + c.vs + c.vbp);
    endfunction

    function automatic out_t reset_out(input cfg_t c);
        out_t o;
        o = '0;
        o.hs = 1'(1 - c.pol);
        o.vs = 1'(1 - c.pol);
        return o;
    endfunction

    // Outputs for raster index pos (pixels since frame origin); fx/fy are the raw lookahead point
    function automatic out_t model_at(input cfg_t c, input int pos);
        out_t o;
        int ht, vt, px, py, q, qx, qy;
        bit hsa, vsa, nl;
        ht = c.ha + c.hfp + c.hs + c.hbp;
        vt = c.va + c.vfp + c.vs + c.vbp;
        px = pos % ht;
        py = (pos / ht) % vt;
        o = '0;
        o.x = 10'(px);
        o.y = 10'(py);
        o.vde = (px < c.ha) && (py < c.va);
        nl  = ((py + 1) % vt) < c.va;
        hsa = (px >= c.ha + c.hfp) && (px < c.ha + c.hfp + c.hs);
        vsa = (py >= c.va + c.vfp) && (py < c.va + c.vfp + c.vs);
        o.hs = hsa ? 1'(c.pol) : 1'(1 - c.pol);
        o.vs = vsa ? 1'(c.pol) : 1'(1 - c.pol);
        o.cdb = {o.vs, o.hs};
        if (o.vde) begin
            o.period = 2'd3;
            o.cdb = 2'b00;
        end else if (c.dvi == 0 && nl && px >= ht - 10 && px <= ht - 3) begin
            o.period = 2'd1;
            o.cdg = 2'b01;
        end else if (c.dvi == 0 && nl && px >= ht - 2) begin
            o.period = 2'd2;
        end
        o.fs = (px == 0) && (py == 0);
        q  = (pos + c.lead) % (ht * vt);
        qx = q % ht;
        qy = q / ht;
        o.fv = (qx < c.ha) && (qy < c.va);
        o.fx = 10'(qx);
        o.fy = 10'(qy);
        return o;
    endfunction

    task automatic check_out(input string tag, input out_t a, input out_t e);
        check({tag, "_vde"},    int'(a.vde),    int'(e.vde));
        check({tag, "_period"}, int'(a.period), int'(e.period));
        check({tag, "_cdblue"}, int'(a.cdb),    int'(e.cdb));
        check({tag, "_cdgreen"},int'(a.cdg),    int'(e.cdg));
        check({tag, "_cdred"},  int'(a.cdr),    int'(e.cdr));
        check({tag, "_hsync"},  int'(a.hs),     int'(e.hs));
        check({tag, "_vsync"},  int'(a.vs),     int'(e.vs));
        check({tag, "_x"},      int'(a.x),      int'(e.x));
        check({tag, "_y"},      int'(a.y),      int'(e.y));
        check({tag, "_fstart"}, int'(a.fs),     int'(e.fs));
        check({tag, "_fvalid"}, int'(a.fv),     int'(e.fv));
        check({tag, "_fetchx"}, int'(a.fx),     int'(e.fx));
        check({tag, "_fetchy"}, int'(a.fy),     int'(e.fy));
    endtask

    always @(posedge pixclk) rst_s <= {rst_c, rst_b, rst_a};

    // Reference model and per-cycle compare for all three instances
    initial begin
        cfg_t  cfg[3];
        int    pos[3];
        bit    known[3];
        int    lfx[3];
        int    lfy[3];
        out_t  e;
        out_t  act[3];
        string tag[3];
        cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2};
        cfg[1] = '{16, 4, 6, 6, 8, 2, 2, 3, 1, 0, 8};
        cfg[2] = '{20, 2, 3, 5, 6, 1, 2, 2, 0, 1, 1};
        tag[0] = "a";
        tag[1] = "b";
        tag[2] = "c";
        for (int i = 0; i < 3; i++) begin
            known[i] = 1'b0;
            pos[i] = 0;
            lfx[i] = 0;
            lfy[i] = 0;
        end

        e = model_at(cfg[0], 790);
        check("model_pre_790_y0", int'(e.period), 1);
        check("model_pre_790_cdg", int'(e.cdg), 1);
        e = model_at(cfg[0], 798);
        check("model_guard_798_y0", int'(e.period), 2);
        check("model_fetch_798_y0", int'({e.fv, e.fx, e.fy}), (1 << 20) | (0 << 10) | 1);
        e = model_at(cfg[0], 479 * 800 + 795);
        check("model_ctrl_795_y479", int'(e.period), 0);
        e = model_at(cfg[0], 479 * 800 + 638);
        check("model_fetch_638_y479", int'(e.fv), 0);
        e = model_at(cfg[0], 524 * 800 + 795);
        check("model_pre_795_y524", int'(e.period), 1);
        e = model_at(cfg[0], 524 * 800 + 798);
        check("model_fetch_wrap", int'({e.fv, e.fx, e.fy}), 1 << 20);
        e = model_at(cfg[0], 490 * 800 + 10);
        check("model_vsync_490", int'(e.vs), 0);
        e = model_at(cfg[0], 489 * 800 + 10);
        check("model_vsync_489", int'(e.vs), 1);
        e = model_at(cfg[0], 751);
        check("model_hsync_751", int'(e.hs), 0);
        e = model_at(cfg[0], 752);
        check("model_hsync_752", int'(e.hs), 1);

        forever begin
            @(negedge pixclk);
            act[0] = {ifa.VDE, ifa.period, ifa.CD_blue, ifa.CD_green, ifa.CD_red, ifa.hsync, ifa.vsync,
                      ifa.x, ifa.y, ifa.frame_start, ifa.fetch_valid, ifa.fetch_x, ifa.fetch_y};
            act[1] = {ifb.VDE, ifb.period, ifb.CD_blue, ifb.CD_green, ifb.CD_red, ifb.hsync, ifb.vsync,
                      ifb.x, ifb.y, ifb.frame_start, ifb.fetch_valid, ifb.fetch_x, ifb.fetch_y};
            act[2] = {ifc.VDE, ifc.period, ifc.CD_blue, ifc.CD_green, ifc.CD_red, ifc.hsync, ifc.vsync,
                      ifc.x, ifc.y, ifc.frame_start, ifc.fetch_valid, ifc.fetch_x, ifc.fetch_y};
            for (int i = 0; i < 3; i++) begin
                if (rst_s[i]) begin
                    known[i] = 1'b1;
                    pos[i] = -1;
                    lfx[i] = 0;
                    lfy[i] = 0;
                    check_out(tag[i], act[i], reset_out(cfg[i]));
                end else if (known[i]) begin
                    pos[i] = (pos[i] + 1) % frame_len(cfg[i]);
                    e = model_at(cfg[i], pos[i]);
                    if (e.fv) begin
                        lfx[i] = int'(e.fx);
                        lfy[i] = int'(e.fy);
                    end else begin
                        e.fx = 10'(lfx[i]);
                        e.fy = 10'(lfy[i]);
                    end
                    check_out(tag[i], act[i], e);
                end
            end
        end
    end

    // Stimulus: directed 640x480 run, randomized resets on the small rasters
    initial begin
        repeat (3) @(negedge pixclk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        fork
            begin
                int vde_cnt;
                int hs_cnt;
                vde_cnt = 0;
                hs_cnt = 0;
                for (int k = 0; k < 1100; k++) begin
                    @(negedge pixclk);
                    if (k < 800) begin
                        vde_cnt += int'(ifa.VDE);
                        hs_cnt += int'(!ifa.hsync);
                    end
                    if (k == 0) begin
                        check("a_first_xy", int'({ifa.x, ifa.y}), 0);
                        check("a_first_vde", int'(ifa.VDE), 1);
                        check("a_first_period", int'(ifa.period), 3);
                        check("a_first_fstart", int'(ifa.frame_start), 1);
                    end
                    if (k == 640) check("a_vde_off_640", int'(ifa.VDE), 0);
                    if (k == 656) check("a_cdblue_hsync", int'(ifa.CD_blue), 2);
                    if (k == 790) check("a_pre_790", int'({ifa.period, ifa.CD_green}), (1 << 2) | 1);
                    if (k == 798) begin
                        check("a_guard_798", int'(ifa.period), 2);
                        check("a_fetch_798", int'({ifa.fetch_valid, ifa.fetch_x, ifa.fetch_y}), (1 << 20) | 1);
                    end
                    if (k == 799) begin
                        check("a_vde_count", vde_cnt, 640);
                        check("a_hsync_count", hs_cnt, 96);
                    end
                    if (k == 800) check("a_line1_video", int'({ifa.period, ifa.x, ifa.y}), (3 << 20) | 1);
                end
                rst_a = 1'b1;
                @(negedge pixclk);
                check("a_rst_vde", int'(ifa.VDE), 0);
                check("a_rst_sync", int'({ifa.hsync, ifa.vsync}), 3);
                check("a_rst_xy", int'({ifa.x, ifa.y}), 0);
                check("a_rst_fetch", int'({ifa.fetch_valid, ifa.frame_start}), 0);
                rst_a = 1'b0;
                @(negedge pixclk);
                check("a_restart_fstart", int'({ifa.frame_start, ifa.x, ifa.y}), 1 << 20);
                repeat (900) @(negedge pixclk);
            end
            begin
                for (int k = 0; k < 5000; k++) begin
                    @(negedge pixclk);
                    if ($urandom_range(0, 299) == 0) begin
                        rst_b = 1'b1;
                        repeat ($urandom_range(1, 3)) @(negedge pixclk);
                        rst_b = 1'b0;
                    end
                end
            end
            begin
                int fs_cnt;
                fs_cnt = 0;
                for (int k = 0; k < 330; k++) begin
                    @(negedge pixclk);
                    fs_cnt += int'(ifc.frame_start);
                    check("c_dvi_no_pre_guard", int'(ifc.period == 2'd1 || ifc.period == 2'd2), 0);
                    check("c_dvi_ctl_zero", int'({ifc.CD_green, ifc.CD_red}), 0);
                end
                check("c_one_fstart_per_frame", fs_cnt, 1);
                for (int k = 0; k < 4600; k++) begin
                    @(negedge pixclk);
                    if ($urandom_range(0, 249) == 0) begin
                        rst_c = 1'b1;
                        repeat ($urandom_range(1, 2)) @(negedge pixclk);
                        rst_c = 1'b0;
                    end
                end
            end
        join
        @(negedge pixclk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
